// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the uart command responder.
//  - state_t      : responder FSM states
//  - *_BYTE_C     : default frame marker and reply byte values
//  - CMD_WR_BIT   : position of the write/read flag inside the CMD byte
//  - sat_inc8     : saturating 8-bit increment used by the error counter
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_DATA    = 3'd2,
    S_CHK     = 3'd3,
    S_EXEC    = 3'd4,
    S_SEND    = 3'd5,
    S_WAIT_HI = 3'd6,
    S_WAIT_LO = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE_C = 8'hA5;
  localparam logic [7:0] ACK_BYTE_C  = 8'h06;
  localparam logic [7:0] NAK_BYTE_C  = 8'h15;

  localparam int CMD_WR_BIT = 7;

  // Counter increment that sticks at 8'hFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = 8'hFF;
    end else begin
      r = v + 8'h01;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_responder.sv
// Register-access responder behind a uart byte link.
// Parses SYNC / CMD / [DATA] / CHK frames from the receiver, performs one
// register write or read per frame and replies ACK, ACK+data or NAK through
// the transmitter handshake.
// Ports:
//  clk, rst_n          clock, synchronous active-low reset
//  rx_valid/rx_data    received byte strobe and value
//  rx_err              receiver framing error strobe
//  tx_start/tx_data    transmit request pulse and byte (held until tx_busy falls)
//  tx_busy             transmitter busy
//  reg_we/reg_re       one-cycle register write/read strobes
//  reg_addr/reg_wdata  register address and write data
//  reg_rdata           combinational register read data for reg_addr
//  err_count           saturating count of aborted or NAKed frames
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int          ADDR_W      = 4,
  parameter int          TIMEOUT_CYC = 12000,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_C,
  parameter logic [7:0]  ACK_BYTE    = ACK_BYTE_C,
  parameter logic [7:0]  NAK_BYTE    = NAK_BYTE_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_err,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              reg_we,
  output logic              reg_re,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic [7:0]        err_count
);

  localparam int             TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t              state_r,     state_s;
  logic [7:0]          cmd_r,       cmd_s;
  logic [7:0]          data_r,      data_s;
  logic                chk_ok_r,    chk_ok_s;
  logic [7:0]          rdata_r,     rdata_s;
  logic                idx_r,       idx_s;
  logic [TMO_W-1:0]    tmo_r,       tmo_s;
  logic [7:0]          err_r,       err_s;
  logic                tx_start_r,  tx_start_s;
  logic [7:0]          tx_data_r,   tx_data_s;
  logic                reg_we_r,    reg_we_s;
  logic                reg_re_r,    reg_re_s;
  logic [ADDR_W-1:0]   reg_addr_r,  reg_addr_s;
  logic [7:0]          reg_wdata_r, reg_wdata_s;
  logic [7:0]          chk_exp_s;
  logic                two_bytes_s;

  // Next-state, datapath and output computation for the frame/reply FSM.
  always_comb begin
    state_s     = state_r;
    cmd_s       = cmd_r;
    data_s      = data_r;
    chk_ok_s    = chk_ok_r;
    rdata_s     = rdata_r;
    idx_s       = idx_r;
    tmo_s       = {TMO_W{1'b0}};
    err_s       = err_r;
    tx_start_s  = 1'b0;
    tx_data_s   = tx_data_r;
    reg_we_s    = 1'b0;
    reg_re_s    = 1'b0;
    reg_addr_s  = reg_addr_r;
    reg_wdata_s = reg_wdata_r;
    chk_exp_s   = cmd_r[CMD_WR_BIT] ? (cmd_r ^ data_r) : cmd_r;
    // Only successful reads carry a second (data) reply byte.
    two_bytes_s = chk_ok_r & ~cmd_r[CMD_WR_BIT];

    case (state_r)
      S_IDLE: begin
        if (rx_valid && !rx_err && (rx_data == SYNC_BYTE)) begin
          state_s = S_CMD;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_CMD, S_DATA, S_CHK: begin
        // A framing error beats a same-cycle byte; silence aborts the frame.
        if (rx_err || (!rx_valid && (tmo_r == TMO_LAST))) begin
          state_s = S_IDLE;
          err_s   = sat_inc8(err_r);
        end else if (rx_valid) begin
          if (state_r == S_CMD) begin
            cmd_s   = rx_data;
            state_s = rx_data[CMD_WR_BIT] ? S_DATA : S_CHK;
          end else if (state_r == S_DATA) begin
            data_s  = rx_data;
            state_s = S_CHK;
          end else begin
            // Strobes are registered here so they appear the cycle after CHK.
            chk_ok_s    = (rx_data == chk_exp_s);
            reg_addr_s  = cmd_r[ADDR_W-1:0];
            reg_wdata_s = data_r;
            reg_we_s    = (rx_data == chk_exp_s) &  cmd_r[CMD_WR_BIT];
            reg_re_s    = (rx_data == chk_exp_s) & ~cmd_r[CMD_WR_BIT];
            if (rx_data == chk_exp_s) begin
              err_s = err_r;
            end else begin
              err_s = sat_inc8(err_r);
            end
            state_s = S_EXEC;
          end
        end else begin
          tmo_s = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end

      S_EXEC: begin
        // reg_re is high this cycle, so reg_rdata belongs to reg_addr.
        rdata_s = reg_rdata;
        idx_s   = 1'b0;
        state_s = S_SEND;
      end

      S_SEND: begin
        if (!tx_busy) begin
          tx_start_s = 1'b1;
          if (idx_r) begin
            tx_data_s = rdata_r;
          end else begin
            tx_data_s = chk_ok_r ? ACK_BYTE : NAK_BYTE;
          end
          state_s = S_WAIT_HI;
        end else begin
          state_s = S_SEND;
        end
      end

      S_WAIT_HI: begin
        if (tx_busy) begin
          state_s = S_WAIT_LO;
        end else begin
          state_s = S_WAIT_HI;
        end
      end

      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (two_bytes_s && !idx_r) begin
            idx_s   = 1'b1;
            state_s = S_SEND;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          state_s = S_WAIT_LO;
        end
      end

      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cmd_r       <= 8'h00;
      data_r      <= 8'h00;
      chk_ok_r    <= 1'b0;
      rdata_r     <= 8'h00;
      idx_r       <= 1'b0;
      tmo_r       <= {TMO_W{1'b0}};
      err_r       <= 8'h00;
      tx_start_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      reg_we_r    <= 1'b0;
      reg_re_r    <= 1'b0;
      reg_addr_r  <= {ADDR_W{1'b0}};
      reg_wdata_r <= 8'h00;
    end else begin
      state_r     <= state_s;
      cmd_r       <= cmd_s;
      data_r      <= data_s;
      chk_ok_r    <= chk_ok_s;
      rdata_r     <= rdata_s;
      idx_r       <= idx_s;
      tmo_r       <= tmo_s;
      err_r       <= err_s;
      tx_start_r  <= tx_start_s;
      tx_data_r   <= tx_data_s;
      reg_we_r    <= reg_we_s;
      reg_re_r    <= reg_re_s;
      reg_addr_r  <= reg_addr_s;
      reg_wdata_r <= reg_wdata_s;
    end
  end

  assign tx_start  = tx_start_r;
  assign tx_data   = tx_data_r;
  assign reg_we    = reg_we_r;
  assign reg_re    = reg_re_r;
  assign reg_addr  = reg_addr_r;
  assign reg_wdata = reg_wdata_r;
  assign err_count = err_r;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: directed frames from the
// block's test list followed by random frames, checked against a frame-level
// reference model (expected writes, reads, reply bytes and error count).
module tb_uart_cmd_responder;

  localparam int T = 40;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       reg_we;
  logic       reg_re;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic [7:0] err_count;

  logic [7:0] regs_env [16];
  logic [7:0] shadow [16];
  int cyc = 0;
  int last_rx_cyc = 0;
  int unsigned tx_q[$], exp_tx[$], wr_q[$], exp_wr[$], rd_q[$], exp_rd[$], lat_q[$];
  int exp_err;
  int n_checks = 0;
  int n_fail = 0;

  uart_cmd_responder #(.ADDR_W(4), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .err_count(err_count)
  );

  assign reg_rdata = regs_env[reg_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file environment and strobe monitor.
  always @(negedge clk) begin
    if (cyc < 2) begin
      for (int i = 0; i < 16; i++) regs_env[i] <= 8'h37 + 8'(i);
    end else begin
      if (reg_we === 1'b1) begin
        wr_q.push_back(int'({reg_addr, reg_wdata}));
        regs_env[reg_addr] <= reg_wdata;
        lat_q.push_back(cyc - last_rx_cyc);
      end
      if (reg_re === 1'b1) begin
        rd_q.push_back(int'(reg_addr));
        lat_q.push_back(cyc - last_rx_cyc);
      end
      if (rx_valid) last_rx_cyc <= cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: accepts tx_start, stays busy a random time.
  initial begin : uart_model
    tx_busy = 1'b0;
    forever begin
      step();
      if (tx_start === 1'b1) begin
        tx_q.push_back(int'(tx_data));
        tx_busy = 1'b1;
        repeat ($urandom_range(2, 6)) step();
        tx_busy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    repeat (gap) step();
  endtask

  // Sends one frame and records what the responder must do with it.
  task automatic send_frame(input bit wr, input logic [2:0] hi, input logic [3:0] addr,
                            input logic [7:0] data, input bit bad, input int gap);
    logic [7:0] cmd, chk;
    cmd = {wr, hi, addr};
    chk = wr ? (cmd ^ data) : cmd;
    if (bad) chk = chk ^ 8'($urandom_range(1, 255));
    send_byte(8'hA5, gap);
    send_byte(cmd, gap);
    if (wr) send_byte(data, gap);
    send_byte(chk, gap);
    if (bad) begin
      exp_tx.push_back(NAK);
      bump_err();
    end else if (wr) begin
      exp_wr.push_back(int'({addr, data}));
      shadow[addr] = data;
      exp_tx.push_back(ACK);
    end else begin
      exp_rd.push_back(int'(addr));
      exp_tx.push_back(ACK);
      exp_tx.push_back(shadow[addr]);
    end
  endtask

  task automatic settle();
    int n = 0;
    while ((tx_q.size() < exp_tx.size() || tx_busy) && n < 400) begin
      step();
      n++;
    end
    check("settle", 32'(n < 400), 32'd1);
    repeat (6) step();
  endtask

  task automatic compare_all(input string tag);
    int unsigned o;
    check({tag, "_tx_n"}, tx_q.size(), exp_tx.size());
    while (exp_tx.size() > 0) begin
      o = (tx_q.size() > 0) ? tx_q.pop_front() : 32'hDEAD;
      check({tag, "_tx"}, o, exp_tx.pop_front());
    end
    check({tag, "_wr_n"}, wr_q.size(), exp_wr.size());
    while (exp_wr.size() > 0) begin
      o = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hDEAD;
      check({tag, "_wr"}, o, exp_wr.pop_front());
    end
    check({tag, "_rd_n"}, rd_q.size(), exp_rd.size());
    while (exp_rd.size() > 0) begin
      o = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD;
      check({tag, "_rd"}, o, exp_rd.pop_front());
    end
    while (lat_q.size() > 0) check({tag, "_lat"}, lat_q.pop_front(), 32'd1);
    check({tag, "_err"}, err_count, exp_err);
    tx_q.delete();
    wr_q.delete();
    rd_q.delete();
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    rx_err = 1'b0;
    exp_err = 0;
    for (int i = 0; i < 16; i++) shadow[i] = 8'h37 + 8'(i);
    repeat (3) step();
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_we_re", {reg_we, reg_re}, 0);
    check("rst_addr_wdata", {reg_addr, reg_wdata}, 0);
    check("rst_err", err_count, 0);
    rst_n = 1'b1;
    step();

    // Directed write A5 83 5A D9.
    send_byte(8'hA5, 1); send_byte(8'h83, 1); send_byte(8'h5A, 1); send_byte(8'hD9, 1);
    exp_wr.push_back(32'h35A); shadow[3] = 8'h5A; exp_tx.push_back(ACK);
    settle(); compare_all("write");

    // Directed read A5 05 05 of register 5 (holds 3C).
    send_byte(8'hA5, 1); send_byte(8'h05, 1); send_byte(8'h05, 1);
    exp_rd.push_back(32'h5); exp_tx.push_back(ACK); exp_tx.push_back(32'h3C);
    settle(); compare_all("read");

    // Bad checksum.
    send_byte(8'hA5, 1); send_byte(8'h83, 1); send_byte(8'h5A, 1); send_byte(8'h00, 1);
    exp_tx.push_back(NAK); bump_err();
    settle(); compare_all("badchk");

    // Timeout after A5 83, then a normal frame.
    send_byte(8'hA5, 0); send_byte(8'h83, T + 1);
    bump_err();
    settle(); compare_all("timeout");
    send_frame(1'b1, 3'd0, 4'd3, 8'h5A, 1'b0, 1);
    settle(); compare_all("after_tmo");

    // Gaps just inside the timeout window must not abort.
    send_frame(1'b1, 3'd5, 4'd9, 8'hC3, 1'b0, T - 2);
    settle(); compare_all("long_gap");

    // Idle noise and idle rx_err are ignored.
    send_byte(8'h00, 1); send_byte(8'hFF, 1);
    rx_err = 1'b1; step(); rx_err = 1'b0; step();
    send_frame(1'b0, 3'd2, 4'd9, 8'h00, 1'b0, 1);
    settle(); compare_all("noise");

    // rx_err after A5 83 aborts the frame.
    send_byte(8'hA5, 0); send_byte(8'h83, 0);
    rx_err = 1'b1; step(); rx_err = 1'b0;
    bump_err();
    send_byte(8'h5A, 1); send_byte(8'hD9, 1);
    settle(); compare_all("rx_err");

    // rx_err coinciding with the CMD byte drops it.
    send_byte(8'hA5, 0);
    rx_valid = 1'b1; rx_data = 8'h83; rx_err = 1'b1; step();
    rx_valid = 1'b0; rx_err = 1'b0;
    bump_err();
    send_byte(8'h5A, 1); send_byte(8'hD9, 1);
    settle(); compare_all("err_wins");

    // Bytes during the reply are dropped.
    send_frame(1'b1, 3'd1, 4'd7, 8'h99, 1'b0, 0);
    send_byte(8'hA5, 0); send_byte(8'hA5, 0); send_byte(8'hA5, 0);
    settle(); compare_all("drop");

    // Random frames.
    for (int k = 0; k < 30; k++) begin
      send_frame(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 5));
      settle();
      compare_all("rand");
    end

    // Error counter saturation.
    for (int k = 0; k < 260; k++) begin
      send_byte(8'hA5, 0);
      rx_err = 1'b1; step(); rx_err = 1'b0; step();
      bump_err();
    end
    settle(); compare_all("saturate");
    check("sat_value", err_count, 8'hFF);

    // Reset while the ACK is on the line.
    send_byte(8'hA5, 1); send_byte(8'h81, 1); send_byte(8'h11, 1); send_byte(8'h90, 0);
    exp_wr.push_back(32'h111); shadow[1] = 8'h11; exp_tx.push_back(ACK);
    n = 0;
    while (tx_busy !== 1'b1 && n < 100) begin step(); n++; end
    check("busy_seen", 32'(n < 100), 32'd1);
    rst_n = 1'b0;
    step();
    check("mid_rst_outs", {tx_start, reg_we, reg_re}, 0);
    check("mid_rst_err", err_count, 0);
    rst_n = 1'b1;
    exp_err = 0;
    settle(); compare_all("mid_rst");
    send_frame(1'b0, 3'd0, 4'd1, 8'h00, 1'b0, 1);
    settle(); compare_all("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
